// File: rtl/act_skew_feeder_pkg.sv
// Shared constants, FSM encoding and drain-length helper for the activation skew feeder.
// Reused by the downstream output collector so both agree on the drain length.
package act_skew_feeder_pkg;

    localparam int ARRAY_ROW  = 12;
    localparam int ARRAY_COL  = 16;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        FEEDER_IDLE   = 2'd0,
        FEEDER_STREAM = 2'd1,
        FEEDER_DRAIN  = 2'd2
    } feeder_state_e;

    // Zeros needed so the last wavefront reaches the bottom row and leaves the last column.
    function automatic int feeder_drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/act_skew_feeder_if.sv
// Stream-in / array-out bundle of the activation skew feeder.
// Perf counter ports exist only when FEEDER_PERF_CNT_EN is defined.
interface act_skew_feeder_if #(
    parameter int ROWS = 12,
    parameter int DW   = 8
);
    logic               s_valid;
    logic               s_ready;
    logic [ROWS*DW-1:0] s_act_vec;
    logic               s_last;
    logic               en_compute;
    logic [ROWS*DW-1:0] out_act_vec;
    logic               busy;
    logic               done;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0]        perf_beats;
    logic [31:0]        perf_stalls;
`endif

    modport master (
        output s_valid, s_act_vec, s_last,
        input  s_ready, en_compute, out_act_vec, busy, done
`ifdef FEEDER_PERF_CNT_EN
        , input perf_beats, perf_stalls
`endif
    );

    modport slave (
        input  s_valid, s_act_vec, s_last,
        output s_ready, en_compute, out_act_vec, busy, done
`ifdef FEEDER_PERF_CNT_EN
        , output perf_beats, perf_stalls
`endif
    );

endinterface

// File: rtl/act_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage enabled shift register; one instance per activation row.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage_q [DEPTH];

    // NOTE: these are flops, not a RAM; each stage is reset so the array sees a clean zero wavefront.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: delays row r by r+1 advances, drives en_compute, drains zeros after s_last.
// Optional perf counters (perf_beats, perf_stalls) under FEEDER_PERF_CNT_EN.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int ROWS = ARRAY_ROW,
    parameter int COLS = ARRAY_COL,
    parameter int DW   = DATA_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    act_skew_feeder_if.slave bus
);

    localparam int DRAIN_LEN = feeder_drain_len(ROWS, COLS);
    localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

    feeder_state_e      state_q;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic               en_compute_q;
    logic               done_q;
    logic               in_drain;
    logic               accept;
    logic               advance;
    logic               drain_end;
    logic [ROWS*DW-1:0] row_in;
    logic [ROWS*DW-1:0] row_out;

    assign in_drain  = (state_q == FEEDER_DRAIN);
    assign accept    = bus.s_valid && !in_drain;
    assign advance   = accept || in_drain;
    assign drain_end = in_drain && (drain_cnt_q == CNT_W'(DRAIN_LEN - 1));
    // Bubbles freeze the lines; zeros enter only while draining.
    assign row_in    = in_drain ? '0 : bus.s_act_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FEEDER_IDLE;
            drain_cnt_q  <= '0;
            en_compute_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            en_compute_q <= advance;
            done_q       <= drain_end;
            case (state_q)
                FEEDER_IDLE: begin
                    if (accept) state_q <= bus.s_last ? FEEDER_DRAIN : FEEDER_STREAM;
                end
                FEEDER_STREAM: begin
                    if (accept && bus.s_last) state_q <= FEEDER_DRAIN;
                end
                FEEDER_DRAIN: begin
                    if (drain_end) begin
                        state_q     <= FEEDER_IDLE;
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: state_q <= FEEDER_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(.DEPTH(r + 1), .DW(DW)) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (advance),
            .din  (row_in[r*DW +: DW]),
            .dout (row_out[r*DW +: DW])
        );
    end

    assign bus.s_ready     = !in_drain;
    assign bus.en_compute  = en_compute_q;
    assign bus.out_act_vec = row_out;
    assign bus.busy        = (state_q != FEEDER_IDLE);
    assign bus.done        = done_q;

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] perf_beats_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (accept) perf_beats_q <= perf_beats_q + 32'd1;
            if ((state_q == FEEDER_STREAM) && !bus.s_valid) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign bus.perf_beats  = perf_beats_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder with a scoreboard of expected skewed output vectors.
module tb_act_skew_feeder;
    import act_skew_feeder_pkg::*;

    localparam int ROWS      = 12;
    localparam int COLS      = 16;
    localparam int DW        = 8;
    localparam int W         = ROWS * DW;
    localparam int DRAIN_LEN = ROWS + COLS - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    act_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) bus ();

    act_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  sb[$];
    logic [W-1:0]  hist[$];
    feeder_state_e m_state = FEEDER_IDLE;
    int            m_cnt = 0;
    logic          pend_adv = 1'b0;
    logic          pend_done = 1'b0;
    logic [W-1:0]  exp_out = '0;
    logic          last_acc = 1'b0;
    int            cyc = 0;
    int            en_seen = 0;
    int            done_cyc = -1;
    int            ready_low = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] mkvec(input logic [DW-1:0] base);
        logic [W-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = base + DW'(r);
        return v;
    endfunction

    // Output after the latest advance: row r carries the input of r advances ago.
    function automatic logic [W-1:0] skewed();
        logic [W-1:0] v;
        logic [W-1:0] src;
        int k;
        v = '0;
        k = hist.size() - 1;
        for (int r = 0; r < ROWS; r++) begin
            if (k - r >= 0) begin
                src = hist[k-r];
                v[r*DW +: DW] = src[r*DW +: DW];
            end
        end
        return v;
    endfunction

    // One clock cycle: drive, check outputs at negedge, then advance the model.
    task automatic tick(input logic v, input logic [W-1:0] vec, input logic last);
        logic exp_ready;
        logic acc;
        logic adv;
        bus.s_valid   = v;
        bus.s_act_vec = vec;
        bus.s_last    = last;
        @(negedge clk);
        cyc++;
        if (pend_adv) begin
            if (sb.size() > 0) exp_out = sb.pop_front();
            else check("scoreboard_empty", W'(1), W'(0));
        end
        exp_ready = (m_state != FEEDER_DRAIN);
        check("out_act_vec", bus.out_act_vec, exp_out);
        check("en_compute", W'(bus.en_compute), W'(pend_adv));
        check("done", W'(bus.done), W'(pend_done));
        check("busy", W'(bus.busy), W'(m_state != FEEDER_IDLE));
        check("s_ready", W'(bus.s_ready), W'(exp_ready));
        if (bus.en_compute) en_seen++;
        if (bus.done) done_cyc = cyc;
        if (!bus.s_ready) ready_low++;

        acc = v && exp_ready;
        adv = acc || (m_state == FEEDER_DRAIN);
        last_acc = acc;
        if (acc && m_state == FEEDER_IDLE) hist.delete();
        if (adv) begin
            hist.push_back((m_state == FEEDER_DRAIN) ? '0 : vec);
            sb.push_back(skewed());
        end
        pend_adv  = adv;
        pend_done = (m_state == FEEDER_DRAIN) && (m_cnt == DRAIN_LEN - 1);
        case (m_state)
            FEEDER_IDLE:   if (acc) m_state = last ? FEEDER_DRAIN : FEEDER_STREAM;
            FEEDER_STREAM: if (acc && last) m_state = FEEDER_DRAIN;
            FEEDER_DRAIN: begin
                if (m_cnt == DRAIN_LEN - 1) begin
                    m_state = FEEDER_IDLE;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: m_state = FEEDER_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without waiting for a clock edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_act_vec", bus.out_act_vec, '0);
        check("rst_en_compute", W'(bus.en_compute), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_s_ready", W'(bus.s_ready), W'(1));
`ifdef FEEDER_PERF_CNT_EN
        check("rst_perf_beats", W'(bus.perf_beats), W'(0));
        check("rst_perf_stalls", W'(bus.perf_stalls), W'(0));
`endif
        m_state   = FEEDER_IDLE;
        m_cnt     = 0;
        pend_adv  = 1'b0;
        pend_done = 1'b0;
        exp_out   = '0;
        sb.delete();
        hist.delete();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
    endtask

    initial begin
        int t;
        int guard;
        bus.s_valid   = 1'b0;
        bus.s_act_vec = '0;
        bus.s_last    = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then IDLE after release.
        apply_reset();
        idle(2);

        // Single-beat tile: diagonal wavefront, 28 en_compute cycles, done 28 cycles later.
        en_seen  = 0;
        done_cyc = -1;
        t = cyc + 1;
        tick(1'b1, mkvec(8'd1), 1'b1);
        idle(32);
        check("skew_en_count", W'(en_seen), W'(1 + DRAIN_LEN));
        check("skew_done_offset", W'(done_cyc - t), W'(DRAIN_LEN + 1));

        // s_last without s_valid must not start a tile.
        tick(1'b0, mkvec(8'h77), 1'b1);
        check("lone_last_busy", W'(bus.busy), W'(0));

        // Bubbles: A, three idle cycles (with stray s_last), B as last.
        en_seen = 0;
        tick(1'b1, mkvec(8'h20), 1'b0);
        tick(1'b0, mkvec(8'h55), 1'b1);
        tick(1'b0, mkvec(8'h55), 1'b1);
        tick(1'b0, mkvec(8'h55), 1'b1);
        tick(1'b1, mkvec(8'h40), 1'b1);
        idle(32);
        check("bubble_en_count", W'(en_seen), W'(2 + DRAIN_LEN));

        // Backpressure: valid held through drain; next beat taken as soon as s_ready returns.
        t = cyc + 1;
        tick(1'b1, mkvec(8'h60), 1'b1);
        ready_low = 0;
        guard = 0;
        do begin
            tick(1'b1, mkvec(8'h80), 1'b0);
            guard++;
        end while (!last_acc && guard < 40);
        check("bp_ready_low", W'(ready_low), W'(DRAIN_LEN));
        check("bp_accept_cycle", W'(cyc - t), W'(DRAIN_LEN + 1));
        tick(1'b1, mkvec(8'hA0), 1'b1);
        idle(32);

        // Reset mid-drain at drain count 10, then a fresh single-beat tile.
        tick(1'b1, mkvec(8'hC1), 1'b1);
        guard = 0;
        while (m_cnt != 10 && guard < 40) begin
            tick(1'b0, '0, 1'b0);
            guard++;
        end
        check("mid_drain_reached", W'(m_cnt), W'(10));
        apply_reset();
        en_seen  = 0;
        done_cyc = -1;
        t = cyc + 1;
        tick(1'b1, mkvec(8'd1), 1'b1);
        idle(32);
        check("post_rst_en_count", W'(en_seen), W'(1 + DRAIN_LEN));
        check("post_rst_done_offset", W'(done_cyc - t), W'(DRAIN_LEN + 1));

        // Five beats with four STREAM stall cycles.
        apply_reset();
        tick(1'b1, mkvec(8'h10), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, mkvec(8'h30), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b1, mkvec(8'h50), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, mkvec(8'h70), 1'b0);
        tick(1'b1, mkvec(8'h90), 1'b1);
        idle(32);
`ifdef FEEDER_PERF_CNT_EN
        check("perf_beats", W'(bus.perf_beats), W'(5));
        check("perf_stalls", W'(bus.perf_stalls), W'(4));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
